// File: rtl/pov_char_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pov_char_sequencer_pkg
// Description : Shared constants and state encoding for the POV character
//               sequencer (character-select blanking code, sequencer states).
// Revision    : 1.0 - initial release
// ============================================================================
package pov_char_sequencer_pkg;

    // Characters per displayed frame; matches the 10-entry string in the mux
    localparam int unsigned c_num_chars_def = 10;

    // Out-of-range character select; the downstream mux outputs 0 for it
    localparam logic [3:0] c_blank_sel = 4'hF;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_SHOW       = 2'd2,
        ST_BLANK      = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/pov_char_sequencer_index_sync.sv
`default_nettype none
// ============================================================================
// Module      : pov_char_sequencer_index_sync
// Description : Two-flop synchronizer for the asynchronous index sensor plus
//               a registered rising-edge detector. o_idx_pulse is one clock
//               wide and appears 3 clocks after the input edge.
// Revision    : 1.0 - initial release
// ============================================================================
module pov_char_sequencer_index_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_index,
    output logic o_idx_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pulse;

    // Synchronize the sensor, then register a one-cycle pulse on its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_index;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= r_sync2 & ~r_sync3;
        end
    end

    assign o_idx_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pov_char_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pov_char_sequencer
// Description : Measures the rotor period from the index sensor, splits each
//               revolution into 2^SLOT_SHIFT column slots and, from slot
//               START_SLOT on, steps character/column indices for the POV
//               character mux and font stage. Blank (4'hF) elsewhere.
// Revision    : 1.0 - initial release
// ============================================================================
module pov_char_sequencer
    import pov_char_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned SLOT_SHIFT    = 7,
    parameter int unsigned NUM_CHARS     = c_num_chars_def,
    parameter int unsigned COLS_PER_CHAR = 6,
    parameter int unsigned START_SLOT    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       index_in,
    output logic [3:0] n_ascci,
    output logic [2:0] col,
    output logic       col_valid,
    output logic       frame_start,
    output logic       period_ok
);

    localparam int unsigned c_tmr_w  = CNT_W - SLOT_SHIFT;
    localparam int unsigned c_slot_w = SLOT_SHIFT + 1;

    localparam logic [CNT_W-1:0]    c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_glitch_lim = CNT_W'(1) << SLOT_SHIFT;
    localparam logic [2:0]          c_last_col   = 3'(COLS_PER_CHAR - 1);
    localparam logic [3:0]          c_last_char  = 4'(NUM_CHARS - 1);
    localparam logic [c_slot_w-1:0] c_start_prev =
        c_slot_w'((START_SLOT == 0) ? 0 : (START_SLOT - 1));

    logic                w_idx_pulse;
    logic                w_rev_sat;
    logic                w_idx_accept;
    logic                w_frame_go;
    logic                w_slot_run;
    logic                w_tick;
    logic [CNT_W-1:0]    w_period_new;
    logic [c_tmr_w-1:0]  w_slot_len_new;
    logic [c_tmr_w-1:0]  w_slot_len;

    logic [CNT_W-1:0]    r_rev_cnt;
    logic [CNT_W-1:0]    r_period_q;
    logic                r_period_ok;
    logic [c_tmr_w-1:0]  r_slot_tmr;
    logic [c_slot_w-1:0] r_slot_idx;
    seq_state_e          r_state;
    logic [3:0]          r_char;
    logic [2:0]          r_col;
    logic [3:0]          r_n_ascci;
    logic                r_col_valid;
    logic                r_frame_start;

    pov_char_sequencer_index_sync u_index_sync (
        .clk         (clk),
        .rst         (rst),
        .i_index     (index_in),
        .o_idx_pulse (w_idx_pulse)
    );

    // Pulses closer than one slot's worth of counts to the last index are glitches.
    // The captured period counts every cycle since the previous accepted pulse,
    // including the pulse cycle itself, so a P-cycle revolution measures as P.
    assign w_rev_sat      = (r_rev_cnt == c_cnt_max);
    assign w_idx_accept   = w_idx_pulse && (r_rev_cnt >= c_glitch_lim);
    assign w_frame_go     = w_idx_accept && r_period_ok;
    assign w_period_new   = w_rev_sat ? r_rev_cnt : (r_rev_cnt + CNT_W'(1));
    assign w_slot_len_new = c_tmr_w'(w_period_new >> SLOT_SHIFT);
    assign w_slot_len     = c_tmr_w'(r_period_q >> SLOT_SHIFT);
    assign w_slot_run     = (r_state == ST_WAIT_START) || (r_state == ST_SHOW);
    assign w_tick         = w_slot_run && (r_slot_tmr == '0);

    // Revolution counter, period capture and period-valid / timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rev_cnt   <= '0;
            r_period_q  <= '0;
            r_period_ok <= 1'b0;
        end else if (w_idx_accept) begin
            r_rev_cnt   <= '0;
            r_period_q  <= w_period_new;
            r_period_ok <= 1'b1;
        end else if (w_rev_sat) begin
            r_period_ok <= 1'b0;
        end else begin
            r_rev_cnt   <= r_rev_cnt + CNT_W'(1);
        end
    end

    // Slot timer: reloads with slot_len-1 at zero, giving one tick per slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_tmr <= '0;
            r_slot_idx <= '0;
        end else if (w_frame_go) begin
            r_slot_tmr <= w_slot_len_new - c_tmr_w'(1);
            r_slot_idx <= '0;
        end else if (w_tick) begin
            r_slot_tmr <= w_slot_len - c_tmr_w'(1);
            if (r_slot_idx != '1) begin
                r_slot_idx <= r_slot_idx + c_slot_w'(1);
            end
        end else if (w_slot_run) begin
            r_slot_tmr <= r_slot_tmr - c_tmr_w'(1);
        end
    end

    // Frame sequencer with registered outputs; a fresh index always restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_char        <= '0;
            r_col         <= '0;
            r_n_ascci     <= c_blank_sel;
            r_col_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_frame_go) begin
                r_char <= '0;
                r_col  <= '0;
                if (START_SLOT == 0) begin
                    r_state       <= ST_SHOW;
                    r_n_ascci     <= 4'd0;
                    r_col_valid   <= (c_last_col != 3'd0);
                    r_frame_start <= 1'b1;
                end else begin
                    r_state       <= ST_WAIT_START;
                    r_n_ascci     <= c_blank_sel;
                    r_col_valid   <= 1'b0;
                end
            end else if (w_rev_sat) begin
                r_state     <= ST_IDLE;
                r_col       <= '0;
                r_n_ascci   <= c_blank_sel;
                r_col_valid <= 1'b0;
            end else if (w_tick) begin
                case (r_state)
                    ST_WAIT_START: begin
                        if (r_slot_idx == c_start_prev) begin
                            r_state       <= ST_SHOW;
                            r_char        <= '0;
                            r_col         <= '0;
                            r_n_ascci     <= 4'd0;
                            r_col_valid   <= (c_last_col != 3'd0);
                            r_frame_start <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            if (r_char == c_last_char) begin
                                r_state     <= ST_BLANK;
                                r_n_ascci   <= c_blank_sel;
                                r_col_valid <= 1'b0;
                            end else begin
                                r_char      <= r_char + 4'd1;
                                r_n_ascci   <= r_char + 4'd1;
                                r_col_valid <= (c_last_col != 3'd0);
                            end
                        end else begin
                            r_col       <= r_col + 3'd1;
                            r_col_valid <= ((r_col + 3'd1) != c_last_col);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign n_ascci     = r_n_ascci;
    assign col         = r_col;
    assign col_valid   = r_col_valid;
    assign frame_start = r_frame_start;
    assign period_ok   = r_period_ok;

endmodule
`default_nettype wire

// File: tb/tb_pov_char_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pov_char_sequencer
// Description : Directed self-checking bench. Instance A uses default
//               parameters; instance B uses CNT_W=16, START_SLOT=0 to cover
//               counter timeout and an immediate frame start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pov_char_sequencer;

    logic       clk;
    logic       rst;
    logic       rst_b;
    logic       index_a;
    logic       index_b;

    logic [3:0] na_ascci;
    logic [2:0] na_col;
    logic       na_col_valid;
    logic       na_frame_start;
    logic       na_period_ok;

    logic [3:0] nb_ascci;
    logic [2:0] nb_col;
    logic       nb_col_valid;
    logic       nb_frame_start;
    logic       nb_period_ok;

    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    pov_char_sequencer dut_a (
        .clk         (clk),
        .rst         (rst),
        .index_in    (index_a),
        .n_ascci     (na_ascci),
        .col         (na_col),
        .col_valid   (na_col_valid),
        .frame_start (na_frame_start),
        .period_ok   (na_period_ok)
    );

    pov_char_sequencer #(
        .CNT_W      (16),
        .START_SLOT (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .index_in    (index_b),
        .n_ascci     (nb_ascci),
        .col         (nb_col),
        .col_valid   (nb_col_valid),
        .frame_start (nb_frame_start),
        .period_ok   (nb_period_ok)
    );

    // 10-unit clock; cyc counts rising edges seen so far
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after rising edge number c
    task automatic adv_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Index rising at cycle e gives idx_pulse at e+3, outputs updated at e+4
    task automatic pulse_a(input int e);
        adv_to(e);
        index_a = 1'b1;
        adv_to(e + 4);
        index_a = 1'b0;
    endtask

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rst_b   = 1'b1;
        index_a = 1'b0;
        index_b = 1'b0;
        fork
            // ---------------- instance A: default parameters ----------------
            begin
                adv_to(3);
                chk("a_rst_n_ascci", 32'(na_ascci), 32'hF);
                chk("a_rst_col", 32'(na_col), 32'd0);
                chk("a_rst_col_valid", 32'(na_col_valid), 32'd0);
                chk("a_rst_frame_start", 32'(na_frame_start), 32'd0);
                chk("a_rst_period_ok", 32'(na_period_ok), 32'd0);
                rst = 1'b0;

                // First pulse: measurement only
                adv_to(1000);
                index_a = 1'b1;
                adv_to(1003);
                chk("a_meas_pok_before", 32'(na_period_ok), 32'd0);
                adv_to(1004);
                index_a = 1'b0;
                chk("a_meas_pok_after", 32'(na_period_ok), 32'd1);
                chk("a_meas_blank", 32'(na_ascci), 32'hF);

                // Second pulse (period 12800): frame; glitch 50 clk later
                pulse_a(13800);
                chk("a_wait_blank", 32'(na_ascci), 32'hF);
                adv_to(13850);
                index_a = 1'b1;
                adv_to(13854);
                index_a = 1'b0;
                adv_to(14603);
                chk("a_pre_start_n", 32'(na_ascci), 32'hF);
                chk("a_pre_start_fs", 32'(na_frame_start), 32'd0);
                adv_to(14604);
                chk("a_start_fs", 32'(na_frame_start), 32'd1);
                chk("a_start_n", 32'(na_ascci), 32'd0);
                chk("a_start_col", 32'(na_col), 32'd0);
                chk("a_start_cv", 32'(na_col_valid), 32'd1);
                adv_to(14605);
                chk("a_fs_one_cycle", 32'(na_frame_start), 32'd0);
                adv_to(14704);
                chk("a_col1", 32'(na_col), 32'd1);
                adv_to(15104);
                chk("a_col5", 32'(na_col), 32'd5);
                chk("a_col5_cv", 32'(na_col_valid), 32'd0);
                adv_to(15204);
                chk("a_char1_n", 32'(na_ascci), 32'd1);
                chk("a_char1_col", 32'(na_col), 32'd0);
                adv_to(20603);
                chk("a_last_n", 32'(na_ascci), 32'd9);
                chk("a_last_col", 32'(na_col), 32'd5);
                adv_to(20604);
                chk("a_end_blank", 32'(na_ascci), 32'hF);
                chk("a_end_cv", 32'(na_col_valid), 32'd0);

                // Third pulse: period unchanged by the glitch
                pulse_a(26600);
                adv_to(27404);
                chk("a_rev3_fs", 32'(na_frame_start), 32'd1);
                adv_to(29810);
                chk("a_char4_n", 32'(na_ascci), 32'd4);
                rst = 1'b1;
                adv_to(29811);
                rst = 1'b0;
                chk("a_midrst_n", 32'(na_ascci), 32'hF);
                chk("a_midrst_col", 32'(na_col), 32'd0);
                chk("a_midrst_pok", 32'(na_period_ok), 32'd0);

                // After reset: first revolution is measurement only
                adv_to(39400);
                index_a = 1'b1;
                adv_to(39403);
                chk("a_postrst_pok_before", 32'(na_period_ok), 32'd0);
                adv_to(39404);
                index_a = 1'b0;
                chk("a_postrst_pok_after", 32'(na_period_ok), 32'd1);
                adv_to(40204);
                chk("a_postrst_no_frame_n", 32'(na_ascci), 32'hF);
                chk("a_postrst_no_frame_fs", 32'(na_frame_start), 32'd0);
                pulse_a(52200);
                adv_to(53004);
                chk("a_resume_fs", 32'(na_frame_start), 32'd1);
                chk("a_resume_n", 32'(na_ascci), 32'd0);

                // Speed-up: pulse 3000 clk later, during SHOW
                adv_to(55200);
                index_a = 1'b1;
                adv_to(55203);
                chk("a_pre_abort_n", 32'(na_ascci), 32'd3);
                chk("a_pre_abort_col", 32'(na_col), 32'd3);
                adv_to(55204);
                index_a = 1'b0;
                chk("a_abort_blank", 32'(na_ascci), 32'hF);
                adv_to(55387);
                chk("a_fast_pre_fs", 32'(na_frame_start), 32'd0);
                adv_to(55388);
                chk("a_fast_fs", 32'(na_frame_start), 32'd1);
                chk("a_fast_n", 32'(na_ascci), 32'd0);
                adv_to(55410);
                chk("a_fast_col0", 32'(na_col), 32'd0);
                adv_to(55411);
                chk("a_fast_col1", 32'(na_col), 32'd1);
            end
            // ------------- instance B: CNT_W=16, START_SLOT=0 ---------------
            begin
                adv_to(3);
                chk("b_rst_n_ascci", 32'(nb_ascci), 32'hF);
                chk("b_rst_period_ok", 32'(nb_period_ok), 32'd0);
                rst_b = 1'b0;

                adv_to(300);
                index_b = 1'b1;
                adv_to(304);
                index_b = 1'b0;
                chk("b_meas_pok", 32'(nb_period_ok), 32'd1);
                chk("b_meas_blank", 32'(nb_ascci), 32'hF);

                // Period 1280 -> slot_len 10; frame starts at t0+1
                adv_to(1580);
                index_b = 1'b1;
                adv_to(1583);
                chk("b_t0_blank", 32'(nb_ascci), 32'hF);
                adv_to(1584);
                index_b = 1'b0;
                chk("b_start_fs", 32'(nb_frame_start), 32'd1);
                chk("b_start_n", 32'(nb_ascci), 32'd0);
                chk("b_start_col", 32'(nb_col), 32'd0);
                chk("b_start_cv", 32'(nb_col_valid), 32'd1);
                adv_to(1585);
                chk("b_fs_one_cycle", 32'(nb_frame_start), 32'd0);
                adv_to(1594);
                chk("b_col1", 32'(nb_col), 32'd1);

                // Index stops: counter saturates 65535 cycles after the reload
                adv_to(67119);
                chk("b_pre_timeout_pok", 32'(nb_period_ok), 32'd1);
                adv_to(67120);
                chk("b_timeout_pok", 32'(nb_period_ok), 32'd0);
                chk("b_timeout_n", 32'(nb_ascci), 32'hF);

                // Two pulses re-measure; display resumes on the second
                adv_to(68000);
                index_b = 1'b1;
                adv_to(68004);
                index_b = 1'b0;
                chk("b_remeas_pok", 32'(nb_period_ok), 32'd1);
                chk("b_remeas_fs", 32'(nb_frame_start), 32'd0);
                chk("b_remeas_n", 32'(nb_ascci), 32'hF);
                adv_to(69280);
                index_b = 1'b1;
                adv_to(69284);
                index_b = 1'b0;
                chk("b_resume_fs", 32'(nb_frame_start), 32'd1);
                chk("b_resume_n", 32'(nb_ascci), 32'd0);
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pov_char_sequencer.md
Name: pov_char_sequencer

Overview:
Upstream driver of the POV character multiplexer. Measures the rotor revolution period from the once-per-turn index sensor and divides each revolution into 2^SLOT_SHIFT angular column slots. Starting at a fixed slot it steps a character index 0..NUM_CHARS-1 and a per-character column index, so the downstream mux selects the right 7-bit ASCII code and the font stage the right column. Outside the display window it drives the out-of-range index 4'hF, which makes the mux output 0.

Parameters:
CNT_W, 24, width of the revolution-period counter (clock cycles)
SLOT_SHIFT, 7, log2 of slots per revolution; slot_len = period >> SLOT_SHIFT
NUM_CHARS, 10, characters per frame (matches the mux's 10 x 7-bit string)
COLS_PER_CHAR, 6, columns per character: 5 font columns plus 1 gap column
START_SLOT, 8, slot after the index at which character 0, column 0 begins

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
index_in  in  1  raw hall/index sensor, asynchronous to clk
n_ascci  out  4  character select to the mux; 4'hF when not displaying
col  out  3  column within the current character, 0..COLS_PER_CHAR-1
col_valid  out  1  high on font columns (col < COLS_PER_CHAR-1) while displaying
frame_start  out  1  one-cycle pulse in the first cycle of char 0 / col 0
period_ok  out  1  a valid period has been measured and has not timed out

Behaviour:
- One clock, clk; reset rst is synchronous, active-high. On rst: n_ascci=4'hF, col=0, col_valid=0, frame_start=0, period_ok=0, state=IDLE, counters=0. Reset mid-frame aborts the frame; outputs take reset values in the following cycle.
- Index path: 2-FF synchronizer, then rising-edge detect produces idx_pulse, 1 cycle wide, 3 clk after the input edge.
- rev_cnt increments every cycle and saturates at all-ones.
- Saturation: period_ok<=0, state<=IDLE, n_ascci<=4'hF.
- On idx_pulse with rev_cnt < 2^SLOT_SHIFT: treat as glitch and ignore completely. rev_cnt keeps counting.
- On any other idx_pulse: period_q<=rev_cnt, rev_cnt<=0, period_ok<=1.
- If period_ok was already 1 before the pulse, start a frame:
  - slot_idx<=0
  - slot timer loaded with slot_len-1, where slot_len = period_q_new >> SLOT_SHIFT
  - state<=WAIT_START
- If period_ok was 0 before the pulse, this revolution is measurement only and state stays IDLE.
- Slot timer counts down and reloads at 0, giving a slot tick every slot_len cycles. Slot k is visible on the registered outputs from cycle t0+1+k*slot_len, where t0 is the idx_pulse cycle.
- States:
  - IDLE: outputs blank; leaves only via the frame-start rule above.
  - WAIT_START: on the tick ending slot START_SLOT-1, go to SHOW with char=0, col=0. If START_SLOT==0, go to SHOW directly at t0.
  - SHOW: n_ascci=char, col=col, col_valid=(col!=COLS_PER_CHAR-1). Each tick: col++. At col==COLS_PER_CHAR-1, col<=0 and char++. At the wrap of char NUM_CHARS-1, go to BLANK.
  - BLANK: n_ascci=4'hF, col=0, col_valid=0 until the next idx_pulse.
- frame_start is high exactly in the first SHOW cycle.
- Simultaneous idx_pulse and slot tick: idx_pulse wins and the frame restarts.
- idx_pulse during SHOW (window longer than the revolution, or a speed-up): abort the current frame and restart from WAIT_START.
- Widths: char counter 4 bits; col counter 3 bits; slot_idx SLOT_SHIFT+1 bits; slot timer CNT_W-SLOT_SHIFT bits.

Decomposition:
- Shared include pov_defs.vh: NUM_CHARS, CHAR_W=7, BLANK_SEL=4'hF, state encodings (IDLE, WAIT_START, SHOW, BLANK).
- One sub-module, index_sync: 2-FF synchronizer plus rising-edge detector producing idx_pulse.

Test Plan:
- Default parameters, index period 12800 clk (slot_len=100): first revolution shows period_ok going 1 at the 1st pulse after the initial measurement and n_ascci stays F. 2nd revolution: frame_start at t0+1+800; n_ascci=0, col 0..5 stepping every 100 clk; col_valid low during col=5; n_ascci=9 ends at slot 68, then F until the next index.
- Reset asserted while n_ascci=4 → next cycle n_ascci=F, col=0, period_ok=0; the next revolution after reset is measurement only.
- Glitch index pulse 50 clk after a valid pulse (< 128) → ignored; period_q and the frame in progress are unchanged.
- CNT_W=16, index stops → at rev_cnt=65535, period_ok=0 and n_ascci=F; the next two pulses re-measure, and display resumes on the second.
- Speed-up: period 12800 then a pulse 3000 clk later during SHOW → frame aborts, period_q=3000, slot_len=23, new frame starts at t0+1+8*23.
- START_SLOT=0 → frame_start in cycle t0+1 with n_ascci=0, col=0.
